// File: rtl/ps2_pkg.sv
// PS/2 key queue: shared event type and scan-code constants.
package ps2_pkg;
  typedef struct packed {
    logic       rpt;
    logic       make;
    logic [8:0] code;
  } ev_t;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;
endpackage

// File: rtl/ps2_key_queue_if.sv
// First-word-fall-through key event stream.
interface ps2_key_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [8:0] ev_code;
  logic       ev_make;
  logic       ev_repeat;

  modport master (
    output ev_valid, ev_code, ev_make, ev_repeat,
    input  ev_ready
  );
  modport slave (
    input  ev_valid, ev_code, ev_make, ev_repeat,
    output ev_ready
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchroniser, clock filter, frame deserialiser,
// odd-parity check and inter-edge timeout.
module ps2_rx #(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] T1   = TW'(1);

  logic [1:0]      csync, dsync;
  logic [FILT-2:0] shr;
  logic [FILT-1:0] win;
  logic            filt, fall, d, par;
  logic [3:0]      bcnt;
  logic [7:0]      sh;
  logic [TW-1:0]   tmr;

  assign d    = dsync[1];
  assign win  = {shr, csync[1]};
  assign fall = ce && filt && (win == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csync <= 2'b11;
      dsync <= 2'b11;
      shr   <= '1;
      filt  <= 1'b1;
      bcnt  <= 4'd0;
      sh    <= 8'd0;
      par   <= 1'b0;
      tmr   <= '0;
      data  <= 8'd0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
      valid <= 1'b0;
      err   <= 1'b0;
      if (ce) begin
        shr <= win[FILT-2:0];
        if (&win)
          filt <= 1'b1;
        else if (win == '0)
          filt <= 1'b0;
      end
      if (fall) begin
        tmr <= '0;
        unique case (bcnt)
          4'd0: begin
            if (!d) bcnt <= 4'd1;
            else    err  <= 1'b1;
          end
          4'd9: begin
            par  <= ^{d, sh};
            bcnt <= 4'd10;
          end
          4'd10: begin
            bcnt <= 4'd0;
            if (d && par) begin
              data  <= sh;
              valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: begin
            sh   <= {d, sh[7:1]};
            bcnt <= bcnt + 4'd1;
          end
        endcase
      end else if (ce && bcnt != 4'd0) begin
        // A stalled frame is abandoned so the next start bit resyncs.
        if (tmr == TMAX) begin
          err  <= 1'b1;
          bcnt <= 4'd0;
          tmr  <= '0;
        end else begin
          tmr <= tmr + T1;
        end
      end
    end
  end
endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 keyboard front end: prefix decode, held-key table,
// autorepeat and an event FIFO.
module ps2_key_queue
  import ps2_pkg::*;
#(
  parameter int KEYS      = 5,
  parameter int DEPTH     = 8,
  parameter int FILT      = 4,
  parameter int TIMEOUT   = 2000,
  parameter int REP_DELAY = 25000,
  parameter int REP_RATE  = 3000
) (
  input  logic clk_sys,
  input  logic bus_reset,
  input  logic ce,
  input  logic ps2_kbd_clk,
  input  logic ps2_kbd_data,
  input  logic rep_en,
  input  logic clear,
  ps2_key_queue_if.master ev,
  output logic held_any,
  output logic overrun,
  output logic frame_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int RMX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW  = $clog2(RMX + 1);
  localparam logic [CNW-1:0] FULL = CNW'(DEPTH);
  localparam logic [AW-1:0]  A1   = AW'(1);
  localparam logic [RW-1:0]  R1   = RW'(1);
  localparam logic [RW-1:0]  DLY  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0]  RTE  = RW'(REP_RATE - 1);

  logic [7:0]            rx_byte;
  logic                  rx_valid, pend, proc;
  logic                  e0, e0_n, brk, brk_n;
  logic [2:0]            skip, skip_n;
  logic [KEYS-1:0][8:0]  tbl, tbl_n, mk_tbl, brk_tbl;
  logic [KEYS:0][8:0]    tx;
  logic [8:0]            code;
  logic                  held, key_ev, ovr_byte;
  logic [RW-1:0]         rcnt, rcnt_n, lim;
  logic                  rphase, rphase_n;
  logic                  push_req, push_rep, do_push, pop, full;
  ev_t                   push_ev, head;
  ev_t                   mem [DEPTH];
  logic [AW-1:0]         wp, rp;
  logic [CNW-1:0]        count;

  ps2_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) u_rx (
    .clk      (clk_sys),
    .rst      (bus_reset),
    .ce       (ce),
    .ps2_clk  (ps2_kbd_clk),
    .ps2_data (ps2_kbd_data),
    .data     (rx_byte),
    .valid    (rx_valid),
    .err      (frame_err)
  );

  // A received byte waits for the next ce tick before decode.
  assign proc = ce && (pend || rx_valid);
  assign full = (count == FULL);
  assign pop  = ev.ev_valid && ev.ev_ready;
  assign head = mem[rp];

  assign ev.ev_valid  = (count != '0);
  assign ev.ev_code   = head.code;
  assign ev.ev_make   = head.make;
  assign ev.ev_repeat = head.rpt;
  assign held_any     = |tbl;

  always_comb begin
    code    = {e0, rx_byte};
    tx      = {9'd0, tbl};
    held    = 1'b0;
    mk_tbl  = tbl;
    brk_tbl = tbl;
    mk_tbl[0] = code;
    for (int i = 1; i < KEYS; i++)
      mk_tbl[i] = tbl[i-1];
    for (int i = 0; i < KEYS; i++) begin
      if (tbl[i] == code) held = 1'b1;
      brk_tbl[i] = held ? tx[i+1] : tbl[i];
    end

    tbl_n    = tbl;
    e0_n     = e0;
    brk_n    = brk;
    skip_n   = skip;
    key_ev   = 1'b0;
    ovr_byte = 1'b0;
    push_req = 1'b0;
    push_rep = 1'b0;
    push_ev  = '0;
    if (proc) begin
      if (skip != 3'd0) begin
        skip_n = skip - 3'd1;
      end else begin
        unique case (1'b1)
          rx_byte == SC_E0: e0_n = 1'b1;
          rx_byte == SC_F0: brk_n = 1'b1;
          rx_byte == SC_E1: skip_n = 3'd7;
          rx_byte == SC_00 || rx_byte == SC_FF: begin
            ovr_byte = 1'b1;
            e0_n     = 1'b0;
            brk_n    = 1'b0;
          end
          default: begin
            e0_n  = 1'b0;
            brk_n = 1'b0;
            if (brk) begin
              tbl_n    = brk_tbl;
              key_ev   = 1'b1;
              push_req = 1'b1;
              push_ev  = {1'b0, 1'b0, code};
            end else if (!held) begin
              tbl_n    = mk_tbl;
              key_ev   = 1'b1;
              push_req = 1'b1;
              push_ev  = {1'b0, 1'b1, code};
            end
          end
        endcase
      end
    end

    rcnt_n   = rcnt;
    rphase_n = rphase;
    lim      = rphase ? RTE : DLY;
    if (!rep_en || tbl[0] == 9'd0 || key_ev) begin
      rcnt_n   = '0;
      rphase_n = 1'b0;
    end else if (ce) begin
      if (rcnt == lim) begin
        rcnt_n   = '0;
        rphase_n = 1'b1;
        push_req = 1'b1;
        push_rep = 1'b1;
        push_ev  = {1'b1, 1'b1, tbl[0]};
      end else begin
        rcnt_n = rcnt + R1;
      end
    end
    do_push = push_req && (!full || pop);
  end

  always_ff @(posedge clk_sys or posedge bus_reset) begin
    if (bus_reset) begin
      pend    <= 1'b0;
      e0      <= 1'b0;
      brk     <= 1'b0;
      skip    <= 3'd0;
      tbl     <= '0;
      rcnt    <= '0;
      rphase  <= 1'b0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      pend <= (pend || rx_valid) && !proc;
      if (clear) begin
        e0      <= 1'b0;
        brk     <= 1'b0;
        skip    <= 3'd0;
        tbl     <= '0;
        rcnt    <= '0;
        rphase  <= 1'b0;
        wp      <= '0;
        rp      <= '0;
        count   <= '0;
        overrun <= 1'b0;
      end else begin
        e0     <= e0_n;
        brk    <= brk_n;
        skip   <= skip_n;
        tbl    <= tbl_n;
        rcnt   <= rcnt_n;
        rphase <= rphase_n;
        if (do_push) wp <= wp + A1;
        if (pop)     rp <= rp + A1;
        count <= count + {{AW{1'b0}}, do_push}
                       - {{AW{1'b0}}, pop};
        if (ovr_byte || (push_req && !push_rep && full && !pop))
          overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !clear) mem[wp] <= push_ev;
  end
endmodule

// File: tb/tb_ps2_key_queue.sv
// Scoreboard bench for ps2_key_queue: directed PS/2 frames,
// expected events queued at stimulus time, popped by a monitor.
module tb_ps2_key_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic kclk = 1'b1;
  logic kdat = 1'b1;
  logic rep_en = 1'b0;
  logic clear = 1'b0;
  logic held_any, overrun, frame_err;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  logic [10:0] expq[$];
  logic [10:0] mon_got, mon_want;

  ps2_key_queue_if evif();

  ps2_key_queue #(
    .KEYS(5), .DEPTH(8), .FILT(4), .TIMEOUT(100),
    .REP_DELAY(400), .REP_RATE(2000)
  ) dut (
    .clk_sys      (clk),
    .bus_reset    (rst),
    .ce           (ce),
    .ps2_kbd_clk  (kclk),
    .ps2_kbd_data (kdat),
    .rep_en       (rep_en),
    .clear        (clear),
    .ev           (evif),
    .held_any     (held_any),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && frame_err) ferr_cnt++;
    if (!rst && evif.ev_valid && evif.ev_ready) begin
      checks++;
      mon_got = {evif.ev_repeat, evif.ev_make, evif.ev_code};
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL event: got %h, required no event", mon_got);
      end else begin
        mon_want = expq.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL event: got %h required %h", mon_got, mon_want);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badp);
    return {1'b1, (~(^b)) ^ badp, b, 1'b0};
  endfunction

  task automatic drive_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      kdat = f[i];
      repeat (4) @(posedge clk);
      kclk = 1'b0;
      repeat (8) @(posedge clk);
      kclk = 1'b1;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit badp = 1'b0);
    drive_bits(mkframe(b, badp), 0, 10);
    kdat = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic make_ev(input logic [8:0] c);
    expq.push_back({1'b0, 1'b1, c});
  endtask

  task automatic brk_ev(input logic [8:0] c);
    expq.push_back({1'b0, 1'b0, c});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events pending, required 0", nm, expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] fill [9];
  logic [7:0] brk6 [5];
  logic [10:0] trunc;
  int fe0;

  initial begin
    fill = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    brk6 = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    evif.ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(evif.ev_valid), 0);
    chk("rst_held", 32'(held_any), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    make_ev(9'h01C);
    send(8'h1C);
    drain("make_1c");
    chk("held_after_make", 32'(held_any), 1);
    brk_ev(9'h01C);
    send(8'hF0);
    send(8'h1C);
    drain("break_1c");
    chk("held_after_break", 32'(held_any), 0);

    rep_en = 1'b1;
    make_ev(9'h175);
    send(8'hE0);
    send(8'h75);
    expq.push_back({1'b1, 1'b1, 9'h175});
    repeat (600) @(posedge clk);
    brk_ev(9'h175);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    drain("repeat_175");
    rep_en = 1'b0;
    chk("held_after_e075", 32'(held_any), 0);

    make_ev(9'h015); send(8'h15);
    make_ev(9'h01D); send(8'h1D);
    make_ev(9'h024); send(8'h24);
    make_ev(9'h02D); send(8'h2D);
    make_ev(9'h02C); send(8'h2C);
    make_ev(9'h035); send(8'h35);
    send(8'h24);
    drain("six_makes");
    brk_ev(9'h015);
    send(8'hF0); send(8'h15);
    drain("break_dropped_15");
    chk("held_after_015_brk", 32'(held_any), 1);
    for (int i = 0; i < 5; i++) begin
      brk_ev({1'b0, brk6[i]});
      send(8'hF0);
      send(brk6[i]);
      if (i == 3) begin
        drain("breaks_4");
        chk("held_one_left", 32'(held_any), 1);
      end
    end
    drain("breaks_5");
    chk("held_all_broken", 32'(held_any), 0);

    @(negedge clk) evif.ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(fill[i]);
    @(negedge clk);
    chk("full_overrun", 32'(overrun), 1);
    chk("full_valid", 32'(evif.ev_valid), 1);
    pulse_clear();
    chk("clear_valid", 32'(evif.ev_valid), 0);
    chk("clear_overrun", 32'(overrun), 0);
    chk("clear_held", 32'(held_any), 0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) make_ev({1'b0, fill[i]});
      send(fill[i]);
    end
    @(negedge clk) evif.ev_ready = 1'b1;
    drain("fifo_eight");
    chk("overrun_sticky", 32'(overrun), 1);
    pulse_clear();
    chk("clear2_overrun", 32'(overrun), 0);

    fe0 = ferr_cnt;
    send(8'h1C, 1'b1);
    repeat (20) @(negedge clk);
    chk("bad_parity_err", 32'(ferr_cnt - fe0), 1);
    chk("bad_parity_noev", 32'(evif.ev_valid), 0);
    make_ev(9'h01C);
    send(8'h1C);
    drain("good_after_bad");
    brk_ev(9'h01C);
    send(8'hF0); send(8'h1C);
    drain("cleanup_1c");

    make_ev(9'h01C);
    send(8'h1C);
    send(8'h00);
    drain("pre_reset");
    chk("pre_reset_overrun", 32'(overrun), 1);
    chk("pre_reset_held", 32'(held_any), 1);
    trunc = mkframe(8'h2A, 1'b0);
    drive_bits(trunc, 0, 5);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(evif.ev_valid), 0);
    chk("mid_rst_held", 32'(held_any), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_frame_err", 32'(frame_err), 0);
    @(negedge clk) rst = 1'b0;
    drive_bits(trunc, 6, 10);
    kdat = 1'b1;
    repeat (150) @(posedge clk);
    chk("trunc_noev", 32'(evif.ev_valid), 0);
    make_ev(9'h01C);
    send(8'h1C);
    drain("resync_1c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_queue.md
PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

Interface
REQ-001 SHALL have parameter KEYS, default 5: held-key table slots (1..8).
REQ-002 SHALL have parameter DEPTH, default 8: event FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter FILT, default 4: PS/2 clock filter length in ce samples (2..8).
REQ-004 SHALL have parameter TIMEOUT, default 2000: maximum ce ticks between falling edges inside a frame.
REQ-005 SHALL have parameters REP_DELAY, default 25000, and REP_RATE, default 3000: autorepeat timing in ce ticks.
REQ-006 SHALL have ports, clock and reset first: clk_sys in 1 system clock; bus_reset in 1 asynchronous, active-high reset; ce in 1 sample/tick enable.
REQ-007 SHALL have ports ps2_kbd_clk in 1 and ps2_kbd_data in 1: raw, unsynchronised PS/2 lines.
REQ-008 SHALL have ports rep_en in 1 (autorepeat enable) and clear in 1 (synchronous flush).
REQ-009 SHALL have ports ev_valid out 1, ev_ready in 1, ev_code out 9 {e0,byte}, ev_make out 1, ev_repeat out 1: FWFT event stream.
REQ-010 SHALL have ports held_any out 1 (table non-empty), overrun out 1 (sticky), frame_err out 1 (one-clk pulse).

Function
REQ-011 SHALL pass both PS/2 lines through a 2-flop synchroniser, then update the filtered clock level only when FILT consecutive ce samples agree.
REQ-012 SHALL sample data on each filtered 1->0 transition: 11-bit frame, start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 SHALL discard a frame and pulse frame_err for bad start, parity or stop, or more than TIMEOUT ce ticks without an edge mid-frame.
REQ-014 SHALL, on E0, set e0; on F0, set brk; on E1, discard the next 7 bytes; all three SHALL emit no event.
REQ-015 SHALL, on any other byte, form code {e0,byte}, process it as a break if brk is set and as a make otherwise, then clear e0 and brk.
REQ-016 SHALL treat bytes 00 and FF as keyboard overrun: set overrun, emit no event, clear prefixes.
REQ-017 SHALL, on a make of a code not held: shift table down, insert the code at slot 0, drop slot KEYS-1 if full, and enqueue {make=1,repeat=0}.
REQ-018 SHALL, on a make of a code already held, update nothing and emit no event (device typematic is suppressed).
REQ-019 SHALL, on a break: remove the matching slot, compact the table, zero slot KEYS-1, and enqueue {make=0,repeat=0}; a break of an unheld code SHALL still be enqueued.
REQ-020 SHALL restart the repeat timer on every make or break.
REQ-021 SHALL, while rep_en=1 and slot 0 is non-zero, enqueue {slot0,make=1,repeat=1} after REP_DELAY ticks, then every REP_RATE ticks.
REQ-022 SHALL hold the timer at zero while rep_en=0 or slot 0 is empty.
REQ-023 SHALL implement the FIFO as DEPTH x 11 bits with a $clog2(DEPTH)+1 count; ev_valid = count!=0; pop on ev_valid & ev_ready on any clk_sys edge.
REQ-024 SHALL, on push when full: drop make/break and set overrun; drop repeat silently; push with a simultaneous pop when full SHALL be accepted.
REQ-025 SHALL enqueue on the ce cycle after stop-bit acceptance, with ev_valid high on the following clk_sys edge.
REQ-026 SHALL, on clear=1: empty the FIFO, zero the table, clear overrun, e0, brk and the E1 skip counter, and stop repeat; the receiver SHALL continue undisturbed.
REQ-027 SHALL give clear priority over a same-cycle push.
REQ-028 SHALL drive held_any = OR of all slots non-zero; code 000 SHALL mean an empty slot.

Reset
REQ-029 SHALL, on bus_reset, immediately set ev_valid=0, count=0, table zero, overrun=0, frame_err=0, e0=brk=0, skip=0, repeat timer=0, receiver idle, filter=1s, and synchronisers=1.
REQ-030 SHALL, after bus_reset de-asserts mid-frame, ignore the partial frame and resynchronise at the next start bit after TIMEOUT.

Structure
REQ-031 SHALL place the event struct {repeat,make,code[8:0]} and constants E0, F0, E1, 00, FF in package ps2_pkg.
REQ-032 SHALL implement filter, deserialiser, parity and timeout as sub-module ps2_rx (byte out, valid pulse, err pulse).

Verification
REQ-033 SHALL cover: 1C, F0 1C -> events {01C,make}, {01C,break}; held_any 1 then 0.
REQ-034 SHALL cover: E0 75 with rep_en=1, held 1.5*REP_DELAY -> make 175 then exactly one repeat event 175.
REQ-035 SHALL cover: KEYS=5, six makes 15 1D 24 2D 2C 35 -> table {35,2C,2D,24,1D}; F0 15 still yields break 015.
REQ-036 SHALL cover: DEPTH=8, ev_ready=0, nine makes -> count 8, overrun=1; clear -> ev_valid=0, overrun=0.
REQ-037 SHALL cover: frame with bad parity -> one frame_err pulse, no event; following good 1C frame yields event.
REQ-038 SHALL cover: bus_reset asserted after bit 5 of a frame -> all outputs 0 that cycle, no event from the truncated frame.
